// File: rtl/pcie_dn_cpld_dec.sv
// ---------------------------------------------------------------------------
// pcie_dn_cpld_dec
// Completion decoder in front of the CplD reorder buffer. Parses the 64-bit
// Avalon-ST RX TLP stream from the hard IP and forwards only good CplD
// payloads as qword beats on DPK_CX_*, together with tag and byte count.
// Bad completion status, out-of-range tags and length mismatches are
// reported as single-cycle pulses. Non-completion TLPs and Cpl without data
// are dropped silently.
//
// Ports
//   PCIE_CLK, PCIE_RST    clock, asynchronous active-high reset
//   RX_ST_*               RX TLP stream in: beat0={DW1,DW0},
//                         beat1={D0|pad,DW2}, then {odd DW, even DW}
//   RX_ST_READY           low in reset, high from the first clock after release
//   DPK_CX_*              payload out, registered, one clock behind the input
//   CPL_ERR_STS/TAG/LEN   one-cycle error pulses
//   CPLD_CNT              count of good CplDs, wraps at 2^32
//
// Handshake: an RX beat is consumed on every clock where RX_ST_VALID=1
// (RX_ST_READY is never dropped after reset). A DPK_CX beat is presented on
// every clock where DPK_CX_DVLD=1; the consumer cannot stall it.
// ---------------------------------------------------------------------------
module pcie_dn_cpld_dec #(
    parameter int P_TAG_NUM = 64
) (
    input  logic        PCIE_CLK,
    input  logic        PCIE_RST,
    input  logic        RX_ST_SOP,
    input  logic        RX_ST_EOP,
    input  logic [63:0] RX_ST_DATA,
    input  logic        RX_ST_VALID,
    output logic        RX_ST_READY,
    output logic        DPK_CX_SOP,
    output logic        DPK_CX_EOP,
    output logic [63:0] DPK_CX_DATA,
    output logic        DPK_CX_DVLD,
    output logic [7:0]  DPK_CX_TAG,
    output logic [11:0] DPK_CX_DCNT,
    output logic        CPL_ERR_STS,
    output logic        CPL_ERR_TAG,
    output logic        CPL_ERR_LEN,
    output logic [31:0] CPLD_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR2 = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Header fields kept from beat0 until DW2 arrives
    logic [7:0]  hdr_ft_q;     // {fmt, type}
    logic [9:0]  hdr_len_q;
    logic [2:0]  hdr_sts_q;
    logic [11:0] hdr_bc_q;

    logic [10:0] rem_q, rem_nxt;       // payload DWs still expected
    logic        first_q, first_nxt;   // next payload beat carries DPK_CX_SOP
    logic        lenbad_q, lenbad_nxt; // excess beat seen, report at EOP
    logic [7:0]  tag_nxt;
    logic [11:0] dcnt_nxt;

    logic        o_sop, o_eop, o_dvld;
    logic [63:0] o_data;
    logic        e_sts, e_tag, e_len, cnt_inc;

    // Decode of the header, valid while state==ST_HDR2
    logic        is_cpl, is_cpld, sts_bad, tag_bad, cpld_ok, addr_a;
    logic [10:0] len_dw, rem_hdr, rem_dat;

    assign is_cpl  = (hdr_ft_q == {3'b000, 5'b01010}) || (hdr_ft_q == {3'b010, 5'b01010});
    assign is_cpld = (hdr_ft_q == {3'b010, 5'b01010});
    assign sts_bad = is_cpl && (hdr_sts_q != 3'b000);
    assign tag_bad = is_cpld && (32'(RX_ST_DATA[15:8]) >= P_TAG_NUM);
    assign cpld_ok = is_cpld && !sts_bad && !tag_bad;
    assign addr_a  = RX_ST_DATA[2];
    // Length 0 encodes 1024 DWs
    assign len_dw  = (hdr_len_q == 10'd0) ? 11'd1024 : {1'b0, hdr_len_q};
    // With lower address bit 2 set, D0 rides in beat1 and counts immediately
    assign rem_hdr = addr_a ? (len_dw - 11'd1) : len_dw;
    assign rem_dat = (rem_q == 11'd1) ? 11'd0 : (rem_q - 11'd2);

    // State register
    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; a SOP beat restarts parsing from any state
    always_comb begin
        state_nxt = state;
        if (RX_ST_VALID) begin
            if (RX_ST_SOP) begin
                state_nxt = RX_ST_EOP ? ST_IDLE : ST_HDR2;
            end else begin
                case (state)
                    ST_HDR2: begin
                        if (RX_ST_EOP)    state_nxt = ST_IDLE;
                        else if (cpld_ok) state_nxt = ST_DATA;
                        else              state_nxt = ST_DROP;
                    end
                    ST_DATA, ST_DROP: begin
                        if (RX_ST_EOP) state_nxt = ST_IDLE;
                    end
                    default: state_nxt = state;
                endcase
            end
        end
    end

    // Output / datapath logic: next values for the registered outputs
    always_comb begin
        o_sop      = 1'b0;
        o_eop      = 1'b0;
        o_dvld     = 1'b0;
        o_data     = 64'h0;
        e_sts      = 1'b0;
        e_tag      = 1'b0;
        e_len      = 1'b0;
        cnt_inc    = 1'b0;
        rem_nxt    = rem_q;
        first_nxt  = first_q;
        lenbad_nxt = lenbad_q;
        tag_nxt    = DPK_CX_TAG;
        dcnt_nxt   = DPK_CX_DCNT;
        if (RX_ST_VALID) begin
            if (RX_ST_SOP) begin
                // Abandoning an unfinished TLP or a one-beat header is a length error
                e_len = (state != ST_IDLE) || RX_ST_EOP;
            end else begin
                case (state)
                    ST_HDR2: begin
                        e_sts = sts_bad;
                        e_tag = tag_bad;
                        if (cpld_ok) begin
                            tag_nxt    = RX_ST_DATA[15:8];
                            dcnt_nxt   = hdr_bc_q;
                            lenbad_nxt = 1'b0;
                            rem_nxt    = rem_hdr;
                            first_nxt  = !addr_a;
                            if (addr_a) begin
                                o_dvld = 1'b1;
                                o_sop  = 1'b1;
                                o_data = {RX_ST_DATA[63:32], 32'h0};
                            end
                            if (RX_ST_EOP) begin
                                o_eop   = addr_a;
                                e_len   = (rem_hdr != 11'd0);
                                cnt_inc = (rem_hdr == 11'd0);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (rem_q == 11'd0) begin
                            // Beyond the Length field: suppress data, still close the packet
                            if (RX_ST_EOP) begin
                                o_dvld = 1'b1;
                                o_eop  = 1'b1;
                                e_len  = 1'b1;
                            end else begin
                                lenbad_nxt = 1'b1;
                            end
                        end else begin
                            o_dvld    = 1'b1;
                            o_sop     = first_q;
                            first_nxt = 1'b0;
                            rem_nxt   = rem_dat;
                            o_data    = (rem_q == 11'd1) ? {32'h0, RX_ST_DATA[31:0]} : RX_ST_DATA;
                            if (RX_ST_EOP) begin
                                o_eop   = 1'b1;
                                e_len   = lenbad_q || (rem_dat != 11'd0);
                                cnt_inc = !(lenbad_q || (rem_dat != 11'd0));
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered outputs and datapath state
    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) begin
            RX_ST_READY <= 1'b0;
            DPK_CX_SOP  <= 1'b0;
            DPK_CX_EOP  <= 1'b0;
            DPK_CX_DATA <= 64'h0;
            DPK_CX_DVLD <= 1'b0;
            DPK_CX_TAG  <= 8'h0;
            DPK_CX_DCNT <= 12'h0;
            CPL_ERR_STS <= 1'b0;
            CPL_ERR_TAG <= 1'b0;
            CPL_ERR_LEN <= 1'b0;
            CPLD_CNT    <= 32'h0;
            rem_q       <= 11'h0;
            first_q     <= 1'b0;
            lenbad_q    <= 1'b0;
            hdr_ft_q    <= 8'h0;
            hdr_len_q   <= 10'h0;
            hdr_sts_q   <= 3'h0;
            hdr_bc_q    <= 12'h0;
        end else begin
            RX_ST_READY <= 1'b1;
            DPK_CX_SOP  <= o_sop;
            DPK_CX_EOP  <= o_eop;
            DPK_CX_DATA <= o_data;
            DPK_CX_DVLD <= o_dvld;
            DPK_CX_TAG  <= tag_nxt;
            DPK_CX_DCNT <= dcnt_nxt;
            CPL_ERR_STS <= e_sts;
            CPL_ERR_TAG <= e_tag;
            CPL_ERR_LEN <= e_len;
            CPLD_CNT    <= CPLD_CNT + {31'h0, cnt_inc};
            rem_q       <= rem_nxt;
            first_q     <= first_nxt;
            lenbad_q    <= lenbad_nxt;
            if (RX_ST_VALID && RX_ST_SOP) begin
                hdr_ft_q  <= RX_ST_DATA[31:24];
                hdr_len_q <= RX_ST_DATA[9:0];
                hdr_sts_q <= RX_ST_DATA[47:45];
                hdr_bc_q  <= RX_ST_DATA[43:32];
            end
        end
    end

endmodule

// File: tb/tb_pcie_dn_cpld_dec.sv
// ---------------------------------------------------------------------------
// tb_pcie_dn_cpld_dec
// Directed bench for the completion decoder. Stimulus tasks push the
// hand-computed expected payload beats and error pulses into queues; a
// monitor on the falling clock edge pops and compares whenever the DUT
// shows DPK_CX_DVLD or an error pulse.
// ---------------------------------------------------------------------------
module tb_pcie_dn_cpld_dec;

    logic        PCIE_CLK;
    logic        PCIE_RST;
    logic        RX_ST_SOP;
    logic        RX_ST_EOP;
    logic [63:0] RX_ST_DATA;
    logic        RX_ST_VALID;
    logic        RX_ST_READY;
    logic        DPK_CX_SOP;
    logic        DPK_CX_EOP;
    logic [63:0] DPK_CX_DATA;
    logic        DPK_CX_DVLD;
    logic [7:0]  DPK_CX_TAG;
    logic [11:0] DPK_CX_DCNT;
    logic        CPL_ERR_STS;
    logic        CPL_ERR_TAG;
    logic        CPL_ERR_LEN;
    logic [31:0] CPLD_CNT;

    pcie_dn_cpld_dec #(.P_TAG_NUM(64)) dut (
        .PCIE_CLK    (PCIE_CLK),
        .PCIE_RST    (PCIE_RST),
        .RX_ST_SOP   (RX_ST_SOP),
        .RX_ST_EOP   (RX_ST_EOP),
        .RX_ST_DATA  (RX_ST_DATA),
        .RX_ST_VALID (RX_ST_VALID),
        .RX_ST_READY (RX_ST_READY),
        .DPK_CX_SOP  (DPK_CX_SOP),
        .DPK_CX_EOP  (DPK_CX_EOP),
        .DPK_CX_DATA (DPK_CX_DATA),
        .DPK_CX_DVLD (DPK_CX_DVLD),
        .DPK_CX_TAG  (DPK_CX_TAG),
        .DPK_CX_DCNT (DPK_CX_DCNT),
        .CPL_ERR_STS (CPL_ERR_STS),
        .CPL_ERR_TAG (CPL_ERR_TAG),
        .CPL_ERR_LEN (CPL_ERR_LEN),
        .CPLD_CNT    (CPLD_CNT)
    );

    // ---------------- clock / reset ----------------
    initial PCIE_CLK = 1'b0;
    always #5 PCIE_CLK = ~PCIE_CLK;

    localparam logic [31:0] PAD = 32'hDEAD_BEEF;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    // expected beat = {sop, eop, tag[7:0], dcnt[11:0], data[63:0]}
    logic [85:0] exp_q[$];
    // expected error pulse = {len, tag, sts}
    logic [2:0]  err_q[$];

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic exp_beat(input logic sop, input logic eop, input logic [7:0] tag,
                            input logic [11:0] dcnt, input logic [63:0] data);
        exp_q.push_back({sop, eop, tag, dcnt, data});
    endtask

    task automatic exp_err(input logic [2:0] code);
        err_q.push_back(code);
    endtask

    // ---------------- monitor ----------------
    always @(negedge PCIE_CLK) begin
        logic [85:0] got_b;
        logic [85:0] want_b;
        logic [2:0]  got_e;
        logic [2:0]  want_e;
        if (DPK_CX_DVLD === 1'b1) begin
            got_b = {DPK_CX_SOP, DPK_CX_EOP, DPK_CX_TAG, DPK_CX_DCNT, DPK_CX_DATA};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected got=%h", got_b);
            end else begin
                want_b = exp_q.pop_front();
                if (got_b !== want_b) begin
                    bad++;
                    $display("FAIL beat got=%h want=%h", got_b, want_b);
                end
            end
        end
        got_e = {CPL_ERR_LEN, CPL_ERR_TAG, CPL_ERR_STS};
        if (got_e !== 3'b000) begin
            total++;
            if (err_q.size() == 0) begin
                bad++;
                $display("FAIL err_unexpected got=%b", got_e);
            end else begin
                want_e = err_q.pop_front();
                if (got_e !== want_e) begin
                    bad++;
                    $display("FAIL err got=%b want=%b", got_e, want_e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic sop, input logic eop, input logic [63:0] d);
        @(posedge PCIE_CLK);
        #1;
        RX_ST_SOP   = sop;
        RX_ST_EOP   = eop;
        RX_ST_DATA  = d;
        RX_ST_VALID = 1'b1;
    endtask

    // Invalid beats carry SOP/EOP and garbage so that qualification is exercised
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge PCIE_CLK);
            #1;
            RX_ST_VALID = 1'b0;
            RX_ST_SOP   = 1'b1;
            RX_ST_EOP   = 1'b1;
            RX_ST_DATA  = {$urandom, $urandom};
        end
    endtask

    function automatic logic [31:0] mk_dw0(input logic [2:0] fmt, input logic [4:0] typ,
                                           input logic [9:0] len);
        return {fmt, typ, 14'd0, len};
    endfunction

    function automatic logic [31:0] mk_dw1(input logic [2:0] sts, input logic [11:0] bc);
        return {16'h0100, sts, 1'b0, bc};
    endfunction

    function automatic logic [31:0] mk_dw2(input logic [7:0] tag, input logic [6:0] lo);
        return {16'h0200, tag, 1'b0, lo};
    endfunction

    // Sends a 3DW-header TLP carrying ndw payload DWs base, base+1, ...
    // with gap invalid clocks before each payload beat after beat1.
    task automatic send_tlp(input logic [31:0] dw0, input logic [31:0] dw1, input logic [31:0] dw2,
                            input int ndw, input logic [31:0] base, input int gap);
        int k;
        send_beat(1'b1, 1'b0, {dw1, dw0});
        if (dw2[2]) begin
            send_beat(1'b0, ndw <= 1, {(ndw >= 1) ? base : PAD, dw2});
            k = 1;
        end else begin
            send_beat(1'b0, ndw == 0, {PAD, dw2});
            k = 0;
        end
        while (k < ndw) begin
            if (gap > 0) idle(gap);
            if (k + 1 < ndw) begin
                send_beat(1'b0, k + 2 >= ndw, {base + 32'(k + 1), base + 32'(k)});
                k += 2;
            end else begin
                send_beat(1'b0, 1'b1, {PAD, base + 32'(k)});
                k += 1;
            end
        end
    endtask

    // T1 shape: CplD tag 5, BC 128, L 32, A 0
    task automatic t1_run(input logic [31:0] base);
        for (int k = 0; k < 16; k++)
            exp_beat(k == 0, k == 15, 8'd5, 12'd128, {base + 32'(2*k + 1), base + 32'(2*k)});
        send_tlp(mk_dw0(3'b010, 5'b01010, 10'd32), mk_dw1(3'b000, 12'd128),
                 mk_dw2(8'd5, 7'h00), 32, base, 0);
        idle(4);
        exp_cnt++;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d", total);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        PCIE_RST    = 1'b1;
        RX_ST_VALID = 1'b0;
        RX_ST_SOP   = 1'b0;
        RX_ST_EOP   = 1'b0;
        RX_ST_DATA  = 64'h0;

        repeat (3) @(posedge PCIE_CLK);
        #1;
        chk("rst_ready", 64'(RX_ST_READY), 64'd0);
        chk("rst_dvld",  64'(DPK_CX_DVLD), 64'd0);
        chk("rst_flags", 64'({DPK_CX_SOP, DPK_CX_EOP, CPL_ERR_STS, CPL_ERR_TAG, CPL_ERR_LEN}), 64'd0);
        chk("rst_data",  DPK_CX_DATA, 64'd0);
        chk("rst_tagcnt", 64'({DPK_CX_TAG, DPK_CX_DCNT}), 64'd0);
        chk("rst_cnt",   64'(CPLD_CNT), 64'd0);
        @(negedge PCIE_CLK);
        PCIE_RST = 1'b0;
        @(posedge PCIE_CLK);
        #1;
        chk("ready_after_rst", 64'(RX_ST_READY), 64'd1);
        idle(2);

        // T1: 18-beat CplD, A=0
        t1_run(32'hA100_0000);
        chk("cnt_t1", 64'(CPLD_CNT), 64'(exp_cnt));

        // T2: L=3, BC=12, A=1
        exp_beat(1'b1, 1'b0, 8'd1, 12'd12, {32'hB200_0000, 32'h0});
        exp_beat(1'b0, 1'b1, 8'd1, 12'd12, {32'hB200_0002, 32'hB200_0001});
        send_tlp(mk_dw0(3'b010, 5'b01010, 10'd3), mk_dw1(3'b000, 12'd12),
                 mk_dw2(8'd1, 7'h04), 3, 32'hB200_0000, 0);
        idle(4);
        exp_cnt++;
        chk("cnt_t2", 64'(CPLD_CNT), 64'(exp_cnt));

        // T3: bad status -> STS pulse only
        exp_err(3'b001);
        send_tlp(mk_dw0(3'b010, 5'b01010, 10'd2), mk_dw1(3'b001, 12'd8),
                 mk_dw2(8'd2, 7'h00), 2, 32'hC300_0000, 0);
        idle(4);
        chk("cnt_t3", 64'(CPLD_CNT), 64'(exp_cnt));

        // T4: tag 70 out of range -> TAG pulse only
        exp_err(3'b010);
        send_tlp(mk_dw0(3'b010, 5'b01010, 10'd2), mk_dw1(3'b000, 12'd8),
                 mk_dw2(8'd70, 7'h00), 2, 32'hC400_0000, 0);
        idle(4);
        chk("cnt_t4", 64'(CPLD_CNT), 64'(exp_cnt));

        // T5a: L=4, A=0, 3 invalid clocks between payload beats
        exp_beat(1'b1, 1'b0, 8'd7, 12'd16, {32'hD500_0001, 32'hD500_0000});
        exp_beat(1'b0, 1'b1, 8'd7, 12'd16, {32'hD500_0003, 32'hD500_0002});
        send_tlp(mk_dw0(3'b010, 5'b01010, 10'd4), mk_dw1(3'b000, 12'd16),
                 mk_dw2(8'd7, 7'h00), 4, 32'hD500_0000, 3);
        idle(4);
        exp_cnt++;
        chk("cnt_t5a", 64'(CPLD_CNT), 64'(exp_cnt));

        // T5b: L=4 but EOP after one payload beat -> LEN, EOP still given
        exp_beat(1'b1, 1'b1, 8'd8, 12'd16, {32'hD600_0001, 32'hD600_0000});
        exp_err(3'b100);
        send_tlp(mk_dw0(3'b010, 5'b01010, 10'd4), mk_dw1(3'b000, 12'd16),
                 mk_dw2(8'd8, 7'h00), 2, 32'hD600_0000, 0);
        idle(4);
        chk("cnt_t5b", 64'(CPLD_CNT), 64'(exp_cnt));

        // Cpl without data, good status: dropped silently
        send_tlp(mk_dw0(3'b000, 5'b01010, 10'd0), mk_dw1(3'b000, 12'd0),
                 mk_dw2(8'd3, 7'h00), 0, 32'h0, 0);
        // Truncated header: SOP and EOP on the first beat
        exp_err(3'b100);
        send_beat(1'b1, 1'b1, {mk_dw1(3'b000, 12'd4), mk_dw0(3'b010, 5'b01010, 10'd1)});
        idle(4);
        chk("cnt_trunc", 64'(CPLD_CNT), 64'(exp_cnt));

        // L=1, A=1: single beat {D0,0} with SOP and EOP
        exp_beat(1'b1, 1'b1, 8'd3, 12'd4, {32'hE700_0000, 32'h0});
        send_tlp(mk_dw0(3'b010, 5'b01010, 10'd1), mk_dw1(3'b000, 12'd4),
                 mk_dw2(8'd3, 7'h04), 1, 32'hE700_0000, 0);
        // L=1, A=0: pad upper DW forced to 0
        exp_beat(1'b1, 1'b1, 8'd63, 12'd4, {32'h0, 32'hE800_0000});
        send_tlp(mk_dw0(3'b010, 5'b01010, 10'd1), mk_dw1(3'b000, 12'd4),
                 mk_dw2(8'd63, 7'h00), 1, 32'hE800_0000, 0);
        idle(4);
        exp_cnt += 2;
        chk("cnt_l1", 64'(CPLD_CNT), 64'(exp_cnt));

        // T6: reset in the middle of a T1 payload
        for (int k = 0; k < 3; k++)
            exp_beat(k == 0, 1'b0, 8'd5, 12'd128, {32'hF900_0000 + 32'(2*k + 1), 32'hF900_0000 + 32'(2*k)});
        send_beat(1'b1, 1'b0, {mk_dw1(3'b000, 12'd128), mk_dw0(3'b010, 5'b01010, 10'd32)});
        send_beat(1'b0, 1'b0, {PAD, mk_dw2(8'd5, 7'h00)});
        for (int k = 0; k < 3; k++)
            send_beat(1'b0, 1'b0, {32'hF900_0000 + 32'(2*k + 1), 32'hF900_0000 + 32'(2*k)});
        @(posedge PCIE_CLK);
        @(negedge PCIE_CLK);
        #2;
        PCIE_RST    = 1'b1;
        RX_ST_VALID = 1'b0;
        #1;
        exp_cnt = 0;
        chk("t6_rst_dvld", 64'({DPK_CX_DVLD, DPK_CX_SOP, DPK_CX_EOP}), 64'd0);
        chk("t6_rst_data", DPK_CX_DATA, 64'd0);
        chk("t6_rst_tag",  64'({DPK_CX_TAG, DPK_CX_DCNT}), 64'd0);
        chk("t6_rst_cnt",  64'(CPLD_CNT), 64'(exp_cnt));
        chk("t6_rst_ready", 64'(RX_ST_READY), 64'd0);
        repeat (2) @(posedge PCIE_CLK);
        @(negedge PCIE_CLK);
        PCIE_RST = 1'b0;
        idle(2);
        t1_run(32'hAA00_0000);
        chk("cnt_t6", 64'(CPLD_CNT), 64'(exp_cnt));

        // T7: MWr 3DW L=2 then CplD L=2 back-to-back
        exp_beat(1'b1, 1'b1, 8'd9, 12'd8, {32'h7700_0001, 32'h7700_0000});
        send_tlp(mk_dw0(3'b010, 5'b00000, 10'd2), {16'h0300, 8'h00, 8'hFF},
                 32'h0000_1000, 2, 32'h6600_0000, 0);
        send_tlp(mk_dw0(3'b010, 5'b01010, 10'd2), mk_dw1(3'b000, 12'd8),
                 mk_dw2(8'd9, 7'h00), 2, 32'h7700_0000, 0);
        idle(4);
        exp_cnt++;
        chk("cnt_t7", 64'(CPLD_CNT), 64'(exp_cnt));

        idle(5);
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        chk("errs_left",  64'(err_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
